// File: rtl/cu_pkg.sv
// Shared encodings for the parametrised computational unit: ALU opcodes,
// data-bus source selects and write-enable bit positions.
package cu_pkg;

    localparam logic [3:0] OP_NEG    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_ADD    = 4'd2;
    localparam logic [3:0] OP_MUL_HI = 4'd3;
    localparam logic [3:0] OP_MUL_LO = 4'd4;
    localparam logic [3:0] OP_XOR    = 4'd5;
    localparam logic [3:0] OP_AND    = 4'd6;
    localparam logic [3:0] OP_NOT    = 4'd7;
    localparam logic [3:0] OP_NOP    = 4'd8;
    localparam logic [3:0] OP_NOP_F  = 4'd15;

    localparam logic [3:0] SRC_X0     = 4'd0;
    localparam logic [3:0] SRC_X1     = 4'd1;
    localparam logic [3:0] SRC_Y0     = 4'd2;
    localparam logic [3:0] SRC_Y1     = 4'd3;
    localparam logic [3:0] SRC_R      = 4'd4;
    localparam logic [3:0] SRC_M      = 4'd5;
    localparam logic [3:0] SRC_I      = 4'd6;
    localparam logic [3:0] SRC_DM     = 4'd7;
    localparam logic [3:0] SRC_PM     = 4'd8;
    localparam logic [3:0] SRC_I_PINS = 4'd9;
    localparam logic [3:0] SRC_ZERO   = 4'd10;

    localparam int RE_X0    = 0;
    localparam int RE_X1    = 1;
    localparam int RE_Y0    = 2;
    localparam int RE_Y1    = 3;
    localparam int RE_R     = 4;
    localparam int RE_M     = 5;
    localparam int RE_I     = 6;
    localparam int RE_UNUSED = 7;
    localparam int RE_O_REG = 8;

    // Decoded side effects of a single-cycle ALU opcode.
    typedef struct packed {
        logic wr_r;
        logic wr_carry;
    } alu_ctl_t;

    function automatic logic is_mul(input logic [3:0] func);
        return (func == OP_MUL_HI) || (func == OP_MUL_LO);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned W x W shift-add multiplier returning one selected half of the product.
// Latency: start edge plus W step edges; result/done are valid during the last step cycle.
// Backpressure: start is ignored while busy; caller must hold off until busy drops.
module seq_multiplier #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel_hi,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           sel_hi_q;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_nxt;
    logic [W:0]     psum;

    // Right-shifting accumulator: add the multiplicand into the top half, then shift.
    always_comb begin
        psum    = {1'b0, acc[2*W-1:W]} + (b_q[0] ? {1'b0, a_q} : '0);
        acc_nxt = {psum, acc[W-1:1]};
    end

    // done marks the cycle whose closing edge performs the final step, so the
    // owner of r can capture the finished half on that same edge.
    assign done   = busy && (cnt == LAST_STEP);
    assign result = sel_hi_q ? acc_nxt[2*W-1:W] : acc_nxt[W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            sel_hi_q <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            busy     <= 1'b0;
        end else if (busy) begin
            acc <= acc_nxt;
            b_q <= b_q >> 1;
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end else if (start) begin
            a_q      <= a;
            b_q      <= b;
            sel_hi_q <= sel_hi;
            cnt      <= '0;
            acc      <= '0;
            busy     <= 1'b1;
        end
    end

endmodule

// File: rtl/param_computational_unit.sv
// W-bit computational unit: data registers, source-select bus, ALU with carry and multiplier.
// Latency: bus combinational, ALU ops one edge, multiplies W+1 edges from start to r.
// Backpressure: ALU executes are dropped while busy; the decoder must stall on busy.
module param_computational_unit
    import cu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   source_sel,
    input  logic [8:0]   reg_en,
    input  logic         i_sel,
    input  logic         x_sel,
    input  logic         y_sel,
    input  logic [3:0]   alu_func,
    input  logic [W-1:0] pm_data,
    input  logic [W-1:0] dm,
    input  logic [W-1:0] i_pins,
    output logic [W-1:0] data_bus,
    output logic [W-1:0] o_reg,
    output logic [W-1:0] i,
    output logic [W-1:0] r,
    output logic         r_eq_0,
    output logic         carry,
    output logic         busy
);
    logic [W-1:0] x0, x1, y0, y1, m;
    logic [W-1:0] x_op, y_op;
    logic [W-1:0] alu_res;
    logic [W:0]   ext;
    logic         alu_c;
    alu_ctl_t     ctl;
    logic         exec;
    logic         mul_start;
    logic         mul_done;
    logic [W-1:0] mul_result;
    logic         unused_reg_en7;

    assign unused_reg_en7 = reg_en[RE_UNUSED];

    always_comb begin
        case (source_sel)
            SRC_X0:     data_bus = x0;
            SRC_X1:     data_bus = x1;
            SRC_Y0:     data_bus = y0;
            SRC_Y1:     data_bus = y1;
            SRC_R:      data_bus = r;
            SRC_M:      data_bus = m;
            SRC_I:      data_bus = i;
            SRC_DM:     data_bus = dm;
            SRC_PM:     data_bus = pm_data;
            SRC_I_PINS: data_bus = i_pins;
            default:    data_bus = '0;
        endcase
    end

    assign x_op = x_sel ? x1 : x0;
    assign y_op = y_sel ? y1 : y0;

    always_comb begin
        alu_res = '0;
        alu_c   = carry;
        ext     = '0;
        ctl     = '0;
        case (alu_func)
            OP_NEG: begin
                alu_res    = -x_op;
                ctl.wr_r   = 1'b1;
            end
            OP_SUB: begin
                // Extra top bit of the widened difference is the borrow.
                ext          = {1'b0, x_op} - {1'b0, y_op};
                alu_res      = ext[W-1:0];
                alu_c        = ext[W];
                ctl.wr_r     = 1'b1;
                ctl.wr_carry = 1'b1;
            end
            OP_ADD: begin
                ext          = {1'b0, x_op} + {1'b0, y_op};
                alu_res      = ext[W-1:0];
                alu_c        = ext[W];
                ctl.wr_r     = 1'b1;
                ctl.wr_carry = 1'b1;
            end
            OP_XOR: begin
                alu_res  = x_op ^ y_op;
                ctl.wr_r = 1'b1;
            end
            OP_AND: begin
                alu_res  = x_op & y_op;
                ctl.wr_r = 1'b1;
            end
            OP_NOT: begin
                alu_res  = ~x_op;
                ctl.wr_r = 1'b1;
            end
            default: ;
        endcase
    end

    assign exec      = reg_en[RE_R] && !busy;
    assign mul_start = exec && is_mul(alu_func);

    seq_multiplier #(.W(W)) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (x_op),
        .b      (y_op),
        .sel_hi (alu_func == OP_MUL_HI),
        .busy   (busy),
        .done   (mul_done),
        .result (mul_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0    <= '0;
            x1    <= '0;
            y0    <= '0;
            y1    <= '0;
            m     <= '0;
            i     <= '0;
            o_reg <= '0;
        end else begin
            if (reg_en[RE_X0])    x0    <= data_bus;
            if (reg_en[RE_X1])    x1    <= data_bus;
            if (reg_en[RE_Y0])    y0    <= data_bus;
            if (reg_en[RE_Y1])    y1    <= data_bus;
            if (reg_en[RE_M])     m     <= data_bus;
            if (reg_en[RE_I])     i     <= i_sel ? i + m : data_bus;
            if (reg_en[RE_O_REG]) o_reg <= data_bus;
        end
    end

    // mul_done and exec are mutually exclusive: exec requires !busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r      <= '0;
            r_eq_0 <= 1'b1;
            carry  <= 1'b0;
        end else if (mul_done) begin
            r      <= mul_result;
            r_eq_0 <= (mul_result == '0);
        end else if (exec && ctl.wr_r) begin
            r      <= alu_res;
            r_eq_0 <= (alu_res == '0);
            if (ctl.wr_carry) begin
                carry <= alu_c;
            end
        end
    end

endmodule

// File: tb/tb_param_computational_unit.sv
// Bench for param_computational_unit: directed plan plus randomized traffic vs. an arithmetic model.
module tb_param_computational_unit;
    import cu_pkg::*;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   source_sel;
    logic [8:0]   reg_en;
    logic         i_sel, x_sel, y_sel;
    logic [3:0]   alu_func;
    logic [W-1:0] pm_data, dm, i_pins;
    logic [W-1:0] data_bus, o_reg, i, r;
    logic         r_eq_0, carry, busy;

    logic [3:0]   src8;
    logic [8:0]   en8;
    logic         isel8, xs8, ys8;
    logic [3:0]   fn8;
    logic [7:0]   pm8, dm8, pins8;
    logic [7:0]   bus8, o_reg8, i8, r8;
    logic         z8, c8, busy8;

    param_computational_unit #(.W(W)) dut (
        .clk(clk), .reset(reset), .source_sel(source_sel), .reg_en(reg_en),
        .i_sel(i_sel), .x_sel(x_sel), .y_sel(y_sel), .alu_func(alu_func),
        .pm_data(pm_data), .dm(dm), .i_pins(i_pins), .data_bus(data_bus),
        .o_reg(o_reg), .i(i), .r(r), .r_eq_0(r_eq_0), .carry(carry), .busy(busy)
    );

    param_computational_unit #(.W(8)) dut8 (
        .clk(clk), .reset(reset), .source_sel(src8), .reg_en(en8),
        .i_sel(isel8), .x_sel(xs8), .y_sel(ys8), .alu_func(fn8),
        .pm_data(pm8), .dm(dm8), .i_pins(pins8), .data_bus(bus8),
        .o_reg(o_reg8), .i(i8), .r(r8), .r_eq_0(z8), .carry(c8), .busy(busy8)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural state plus a countdown for a pending product.
    logic [W-1:0] m_x0, m_x1, m_y0, m_y1, m_m, m_i, m_o, m_r, m_pend;
    bit           m_z, m_c;
    int           m_left;

    task automatic model_reset();
        m_x0 = '0; m_x1 = '0; m_y0 = '0; m_y1 = '0;
        m_m = '0; m_i = '0; m_o = '0; m_r = '0; m_pend = '0;
        m_z = 1'b1; m_c = 1'b0; m_left = 0;
    endtask

    function automatic logic [W-1:0] model_bus(input logic [3:0] sel);
        case (sel)
            4'd0: return m_x0;
            4'd1: return m_x1;
            4'd2: return m_y0;
            4'd3: return m_y1;
            4'd4: return m_r;
            4'd5: return m_m;
            4'd6: return m_i;
            4'd7: return dm;
            4'd8: return pm_data;
            4'd9: return i_pins;
            default: return '0;
        endcase
    endfunction

    task automatic model_edge();
        logic [W-1:0] bus, old_i, old_m;
        int a, b, res;
        bit wr;
        bus   = model_bus(source_sel);
        old_i = m_i;
        old_m = m_m;
        a     = int'(x_sel ? m_x1 : m_x0);
        b     = int'(y_sel ? m_y1 : m_y0);
        res   = 0;
        wr    = 1'b0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_r = m_pend;
                m_z = (m_pend == 0);
            end
        end else if (reg_en[4]) begin
            case (int'(alu_func))
                0: begin res = (MOD - a) % MOD; wr = 1'b1; end
                1: begin res = (a - b + MOD) % MOD; m_c = (a < b); wr = 1'b1; end
                2: begin res = (a + b) % MOD; m_c = ((a + b) >= MOD); wr = 1'b1; end
                3: begin m_pend = W'((a * b) / MOD); m_left = W; end
                4: begin m_pend = W'((a * b) % MOD); m_left = W; end
                5: begin res = a ^ b; wr = 1'b1; end
                6: begin res = a & b; wr = 1'b1; end
                7: begin res = (MOD - 1) - a; wr = 1'b1; end
                default: ;
            endcase
            if (wr) begin
                m_r = W'(res);
                m_z = (res == 0);
            end
        end
        if (reg_en[0]) m_x0 = bus;
        if (reg_en[1]) m_x1 = bus;
        if (reg_en[2]) m_y0 = bus;
        if (reg_en[3]) m_y1 = bus;
        if (reg_en[5]) m_m  = bus;
        if (reg_en[6]) m_i  = i_sel ? W'((int'(old_i) + int'(old_m)) % MOD) : bus;
        if (reg_en[8]) m_o  = bus;
    endtask

    task automatic compare_all();
        check("r", r, m_r);
        check("i", i, m_i);
        check("o_reg", o_reg, m_o);
        check("r_eq_0", r_eq_0, m_z);
        check("carry", carry, m_c);
        check("busy", busy, m_left > 0);
        check("data_bus", data_bus, model_bus(source_sel));
    endtask

    task automatic drive(input logic [3:0] src, input logic [W-1:0] pm, input logic [8:0] en,
                         input logic xs, input logic ys, input logic [3:0] fn, input logic is);
        source_sel = src;
        pm_data    = pm;
        reg_en     = en;
        x_sel      = xs;
        y_sel      = ys;
        alu_func   = fn;
        i_sel      = is;
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic load(input int bit_idx, input logic [W-1:0] val);
        drive(SRC_PM, val, 9'(1 << bit_idx), 1'b0, 1'b0, OP_NOP, 1'b0);
    endtask

    task automatic alu(input logic [3:0] fn, input logic xs, input logic ys);
        drive(SRC_R, '0, 9'h010, xs, ys, fn, 1'b0);
    endtask

    task automatic idle();
        drive(SRC_R, '0, 9'h000, 1'b0, 1'b0, OP_NOP, 1'b0);
    endtask

    // Asserted and released between edges; outputs must respond with no clock.
    task automatic pulse_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_r_eq_0", r_eq_0, 1);
        check("rst_carry", carry, 0);
        check("rst_busy", busy, 0);
        check("rst_r", r, 0);
        for (int s = 0; s <= 6; s++) begin
            source_sel = 4'(s);
            #1;
            check("rst_bus", data_bus, 0);
        end
        reset = 1'b0;
    endtask

    task automatic mul_run(input logic [3:0] fn, input logic [W-1:0] exp_r, input logic exp_c);
        alu(fn, 1'b1, 1'b1);
        check("mul_busy_start", busy, 1);
        for (int k = 1; k < W; k++) begin
            idle();
            check("mul_busy_hold", busy, 1);
        end
        idle();
        check("mul_busy_end", busy, 0);
        check("mul_r", r, exp_r);
        check("mul_carry", carry, exp_c);
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        source_sel = '0; reg_en = '0; i_sel = 0; x_sel = 0; y_sel = 0;
        alu_func = '0; pm_data = '0; dm = '0; i_pins = '0;
        src8 = SRC_PM; en8 = '0; isel8 = 0; xs8 = 0; ys8 = 0; fn8 = '0;
        pm8 = '0; dm8 = '0; pins8 = '0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("w8_reset_o_reg", o_reg8, 0);

        // Dirty every register, then reset mid-cycle.
        load(RE_X0, 4'h5); load(RE_X1, 4'h6); load(RE_Y0, 4'h7); load(RE_Y1, 4'h1);
        load(RE_M, 4'h2);  load(RE_I, 4'h3);
        alu(OP_ADD, 1'b0, 1'b0);
        pulse_reset();

        // Add / subtract with carry and borrow.
        load(RE_X0, 4'h9); load(RE_Y0, 4'h8);
        alu(OP_ADD, 1'b0, 1'b0);
        check("add_r", r, 4'h1); check("add_c", carry, 1); check("add_z", r_eq_0, 0);
        load(RE_X0, 4'h3); load(RE_Y0, 4'h3);
        alu(OP_SUB, 1'b0, 1'b0);
        check("sub_r", r, 4'h0); check("sub_c", carry, 0); check("sub_z", r_eq_0, 1);
        load(RE_X0, 4'h2); load(RE_Y0, 4'h5);
        alu(OP_SUB, 1'b0, 1'b0);
        check("sub_borrow_r", r, 4'hD); check("sub_borrow_c", carry, 1);

        // Multiply 0xD x 0xB = 0x8F.
        load(RE_X1, 4'hD); load(RE_Y1, 4'hB);
        mul_run(OP_MUL_LO, 4'hF, 1'b1);
        mul_run(OP_MUL_HI, 4'h8, 1'b1);

        // Operand write and execute while busy.
        alu(OP_MUL_LO, 1'b1, 1'b1);
        drive(SRC_PM, 4'h0, 9'h012, 1'b1, 1'b1, OP_ADD, 1'b0);
        idle(); idle(); idle();
        check("hazard_r", r, 4'hF); check("hazard_busy", busy, 0);
        alu(OP_ADD, 1'b1, 1'b1);
        check("after_hazard_r", r, 4'hB); check("after_hazard_c", carry, 0);

        // Reset during a multiply, then a clean multiply.
        load(RE_X1, 4'hD);
        alu(OP_MUL_LO, 1'b1, 1'b1);
        idle(); idle();
        pulse_reset();
        load(RE_X1, 4'hD); load(RE_Y1, 4'hB);
        mul_run(OP_MUL_HI, 4'h8, 1'b0);

        // Index update and output register.
        load(RE_M, 4'h3); load(RE_I, 4'hE);
        drive(SRC_ZERO, '0, 9'h040, 1'b0, 1'b0, OP_NOP, 1'b1);
        check("i_plus_m", i, 4'h1);
        i_pins = 4'hA;
        drive(SRC_I_PINS, '0, 9'h100, 1'b0, 1'b0, OP_NOP, 1'b0);
        check("o_reg_pins", o_reg, 4'hA);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                pulse_reset();
            end else begin
                dm     = W'($urandom);
                i_pins = W'($urandom);
                drive(4'($urandom), W'($urandom), 9'($urandom), 1'($urandom), 1'($urandom),
                      4'($urandom_range(0, 15)), 1'($urandom));
            end
        end

        // W=8: 0xFF x 0xFF high half.
        pm8 = 8'hFF; src8 = SRC_PM; en8 = 9'h00A;
        @(posedge clk); #1;
        check("w8_bus", bus8, 8'hFF);
        en8 = 9'h010; fn8 = OP_MUL_HI; xs8 = 1'b1; ys8 = 1'b1;
        @(posedge clk); #1;
        en8 = '0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy8) break;
            cnt++;
            @(posedge clk); #1;
        end
        check("w8_busy_cycles", cnt, 8);
        check("w8_r", r8, 8'hFE);
        check("w8_r_eq_0", z8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
